// File: rtl/encoder_scanner.sv
// rtl/encoder_scanner.sv - time-multiplexed quadrature decoder for CHANNELS rotary encoders
//
// Purpose: one shared decode/update datapath serves every encoder. A round-robin
// scan pointer visits one channel per clock; in that slot the channel's
// synchronized pins are compared with the pins seen in its previous slot, and
// the channel value moves by its runtime step.
//
// Ports:
//   clk        single clock
//   reset      asynchronous active-low reset
//   a, b       raw encoder pins, one bit per channel, asynchronous
//   cfg_we     step-register write strobe
//   cfg_sel    step-register index; values >= CHANNELS are ignored
//   cfg_step   new step value
//   clr        per-channel level-sensitive value clear
//   values     packed counts, channel i at [i*WIDTH +: WIDTH]
//   upd_valid  one-cycle pulse, lags the value change it reports by one cycle
//   upd_chan   channel index qualified by upd_valid
module encoder_scanner #(
  parameter int WIDTH     = 8,
  parameter int CHANNELS  = 3,
  parameter int INC_VALUE = 1,
  parameter int SATURATE  = 0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [CHANNELS-1:0]         a,
  input  logic [CHANNELS-1:0]         b,
  input  logic                        cfg_we,
  input  logic [$clog2(CHANNELS)-1:0] cfg_sel,
  input  logic [WIDTH-1:0]            cfg_step,
  input  logic [CHANNELS-1:0]         clr,
  output logic [CHANNELS*WIDTH-1:0]   values,
  output logic                        upd_valid,
  output logic [$clog2(CHANNELS)-1:0] upd_chan
);

  localparam int SW = $clog2(CHANNELS);
  localparam logic [SW-1:0] LAST = SW'(CHANNELS - 1);

  // Two-flop synchronizers on every pin
  logic [CHANNELS-1:0] a_meta_q, a_meta_d, sa_q, sa_d;
  logic [CHANNELS-1:0] b_meta_q, b_meta_d, sb_q, sb_d;

  // Per-channel state
  logic [CHANNELS-1:0]            old_a_q, old_a_d, old_b_q, old_b_d;
  logic [CHANNELS-1:0][WIDTH-1:0] val_q, val_d, step_q, step_d;

  // Scan pointer and update report pipeline
  logic [SW-1:0] ptr_q, ptr_d;
  logic          pend_q, pend_d;
  logic [SW-1:0] pend_chan_q, pend_chan_d;
  logic          upd_valid_q, upd_valid_d;
  logic [SW-1:0] upd_chan_q, upd_chan_d;

  // Shared slot datapath
  logic             cur_sa, cur_sb, cur_oa, cur_ob, cur_clr;
  logic [3:0]       key;
  logic             inc, dec;
  logic [WIDTH-1:0] cur_val, cur_step, new_val;
  logic [WIDTH:0]   sum_ext, diff_ext;
  logic             changed;

  always_comb begin
    cur_sa   = sa_q[ptr_q];
    cur_sb   = sb_q[ptr_q];
    cur_oa   = old_a_q[ptr_q];
    cur_ob   = old_b_q[ptr_q];
    cur_clr  = clr[ptr_q];
    cur_val  = val_q[ptr_q];
    cur_step = step_q[ptr_q];

    // One count per detent: A rising with B low, or A falling with B high
    // (and the mirror pair for the opposite direction).
    key = {cur_sa, cur_oa, cur_sb, cur_ob};
    inc = (key == 4'b1000) || (key == 4'b0111);
    dec = (key == 4'b0010) || (key == 4'b1101);

    // The extra top bit is the carry/borrow used for clamping.
    sum_ext  = {1'b0, cur_val} + {1'b0, cur_step};
    diff_ext = {1'b0, cur_val} - {1'b0, cur_step};

    new_val = cur_val;
    if (inc) begin
      if ((SATURATE != 0) && sum_ext[WIDTH]) new_val = '1;
      else                                   new_val = sum_ext[WIDTH-1:0];
    end else if (dec) begin
      if ((SATURATE != 0) && diff_ext[WIDTH]) new_val = '0;
      else                                    new_val = diff_ext[WIDTH-1:0];
    end

    // A zero step, a clamp at the rail, or a concurrent clear leaves nothing to report.
    changed = (new_val != cur_val) && !cur_clr;
  end

  always_comb begin
    a_meta_d = a;
    b_meta_d = b;
    sa_d     = a_meta_q;
    sb_d     = b_meta_q;

    ptr_d = (ptr_q == LAST) ? '0 : ptr_q + SW'(1);

    // History advances in the slot even when a clear swallows the update.
    old_a_d        = old_a_q;
    old_b_d        = old_b_q;
    old_a_d[ptr_q] = cur_sa;
    old_b_d[ptr_q] = cur_sb;

    for (int i = 0; i < CHANNELS; i++) begin
      val_d[i] = val_q[i];
      if (clr[i])                  val_d[i] = '0;
      else if (ptr_q == SW'(i))    val_d[i] = new_val;

      // The slot reads step_q, so a write landing in the same slot applies next time round.
      // Indices >= CHANNELS match no i and are dropped.
      step_d[i] = step_q[i];
      if (cfg_we && (int'(cfg_sel) == i)) step_d[i] = cfg_step;
    end

    pend_d      = changed;
    pend_chan_d = ptr_q;
    upd_valid_d = pend_q;
    upd_chan_d  = pend_q ? pend_chan_q : upd_chan_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_meta_q    <= '0;
      b_meta_q    <= '0;
      sa_q        <= '0;
      sb_q        <= '0;
      old_a_q     <= '0;
      old_b_q     <= '0;
      val_q       <= '0;
      step_q      <= {CHANNELS{WIDTH'(INC_VALUE)}};
      ptr_q       <= '0;
      pend_q      <= 1'b0;
      pend_chan_q <= '0;
      upd_valid_q <= 1'b0;
      upd_chan_q  <= '0;
    end else begin
      a_meta_q    <= a_meta_d;
      b_meta_q    <= b_meta_d;
      sa_q        <= sa_d;
      sb_q        <= sb_d;
      old_a_q     <= old_a_d;
      old_b_q     <= old_b_d;
      val_q       <= val_d;
      step_q      <= step_d;
      ptr_q       <= ptr_d;
      pend_q      <= pend_d;
      pend_chan_q <= pend_chan_d;
      upd_valid_q <= upd_valid_d;
      upd_chan_q  <= upd_chan_d;
    end
  end

  // Packed 2-D layout already places channel i at [i*WIDTH +: WIDTH].
  assign values    = val_q;
  assign upd_valid = upd_valid_q;
  assign upd_chan  = upd_chan_q;

endmodule

// File: tb/tb_encoder_scanner.sv
// tb/tb_encoder_scanner.sv - directed self-checking bench for encoder_scanner
module tb_encoder_scanner;

  localparam int W = 8;
  localparam int N = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           reset;
  logic [N-1:0]   a, b, clr;
  logic           cfg_we;
  logic [1:0]     cfg_sel;
  logic [W-1:0]   cfg_step;
  logic [N*W-1:0] values_w, values_s;
  logic           upd_valid_w, upd_valid_s;
  logic [1:0]     upd_chan_w, upd_chan_s;

  encoder_scanner #(.WIDTH(W), .CHANNELS(N), .INC_VALUE(1), .SATURATE(0)) dut_w (
    .clk(clk), .reset(reset), .a(a), .b(b), .cfg_we(cfg_we), .cfg_sel(cfg_sel),
    .cfg_step(cfg_step), .clr(clr), .values(values_w), .upd_valid(upd_valid_w),
    .upd_chan(upd_chan_w)
  );

  encoder_scanner #(.WIDTH(W), .CHANNELS(N), .INC_VALUE(1), .SATURATE(1)) dut_s (
    .clk(clk), .reset(reset), .a(a), .b(b), .cfg_we(cfg_we), .cfg_sel(cfg_sel),
    .cfg_step(cfg_step), .clr(clr), .values(values_s), .upd_valid(upd_valid_s),
    .upd_chan(upd_chan_s)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int t0       = 0;
  int upd_cyc_w[$], upd_ch_w[$], upd_cyc_s[$], upd_ch_s[$], vchg_w[$];
  logic [N*W-1:0] prev_w = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] vw(input int ch);
    return 32'(values_w[ch*W +: W]);
  endfunction

  function automatic logic [31:0] vs(input int ch);
    return 32'(values_s[ch*W +: W]);
  endfunction

  // Advance n cycles, sampling at the falling edge and logging events.
  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      cyc++;
      if (upd_valid_w === 1'b1) begin
        upd_cyc_w.push_back(cyc);
        upd_ch_w.push_back(int'(upd_chan_w));
      end
      if (upd_valid_s === 1'b1) begin
        upd_cyc_s.push_back(cyc);
        upd_ch_s.push_back(int'(upd_chan_s));
      end
      if (values_w !== prev_w) vchg_w.push_back(cyc);
      prev_w = values_w;
    end
  endtask

  task automatic clear_log();
    upd_cyc_w.delete();
    upd_ch_w.delete();
    upd_cyc_s.delete();
    upd_ch_s.delete();
    vchg_w.delete();
  endtask

  // Exactly one change on the wrap instance: channel, latency bound, and a
  // single upd_valid pulse one cycle after the value moved.
  task automatic chk_one_w(input string tag, input int ch, input int start);
    chk({tag, "_nupd"}, upd_cyc_w.size(), 1);
    chk({tag, "_nvchg"}, vchg_w.size(), 1);
    if (upd_cyc_w.size() == 1 && vchg_w.size() == 1) begin
      chk({tag, "_chan"}, upd_ch_w[0], ch);
      chk({tag, "_lat_ok"}, 32'(vchg_w[0] - start <= N + 2), 1);
      chk({tag, "_upd_lag"}, upd_cyc_w[0] - vchg_w[0], 1);
    end
  endtask

  initial begin
    reset    = 1'b0;
    a        = '1;
    b        = '1;
    clr      = '0;
    cfg_we   = 1'b0;
    cfg_sel  = '0;
    cfg_step = '0;

    // Reset with pins high
    step(3);
    chk("rst_values_w", values_w, 0);
    chk("rst_values_s", values_s, 0);
    chk("rst_upd_valid", {upd_valid_w, upd_valid_s}, 0);
    chk("rst_upd_chan", upd_chan_w, 0);
    chk("rst_ptr", dut_w.ptr_q, 0);
    reset = 1'b1;
    clear_log();
    for (int k = 1; k <= 20; k++) begin
      step(1);
      chk("idle_ptr", dut_w.ptr_q, k % N);
    end
    chk("idle_values_w", values_w, 0);
    chk("idle_values_s", values_s, 0);
    chk("idle_nupd_w", upd_cyc_w.size(), 0);
    chk("idle_nupd_s", upd_cyc_s.size(), 0);
    a = '0;
    b = '0;
    step(8);
    chk("fall_values_w", values_w, 0);
    chk("fall_nupd_w", upd_cyc_w.size(), 0);

    // Clockwise step on channel 1
    clear_log();
    t0 = cyc;
    a[1] = 1'b1;
    step(8);
    chk("cw1_val_w", vw(1), 1);
    chk("cw1_val_s", vs(1), 1);
    chk_one_w("cw1", 1, t0);
    chk("cw1_nupd_s", upd_cyc_s.size(), 1);

    // Counter-clockwise from 0 on channel 0: wrap vs clamp
    clear_log();
    t0 = cyc;
    b[0] = 1'b1;
    step(8);
    chk("ccw0_wrap", vw(0), 255);
    chk_one_w("ccw0", 0, t0);
    chk("ccw0_sat", vs(0), 0);
    chk("ccw0_sat_nupd", upd_cyc_s.size(), 0);

    // Step of 100 on channel 2, three detents
    cfg_we = 1'b1; cfg_sel = 2'd2; cfg_step = 8'd100;
    step(1);
    cfg_we = 1'b0;
    clear_log();
    t0 = cyc;
    a[2] = 1'b1;
    step(8);
    chk("cfg_d1_w", vw(2), 100);
    chk("cfg_d1_s", vs(2), 100);
    chk_one_w("cfg_d1", 2, t0);
    clear_log();
    b[2] = 1'b1;
    step(8);
    chk("cfg_half_w", vw(2), 100);
    chk("cfg_half_nupd", upd_cyc_w.size(), 0);
    clear_log();
    t0 = cyc;
    a[2] = 1'b0;
    step(8);
    chk("cfg_d2_w", vw(2), 200);
    chk("cfg_d2_s", vs(2), 200);
    chk_one_w("cfg_d2", 2, t0);
    b[2] = 1'b0;
    step(8);
    clear_log();
    t0 = cyc;
    a[2] = 1'b1;
    step(8);
    chk("cfg_d3_wrap", vw(2), 44);
    chk("cfg_d3_sat", vs(2), 255);
    chk_one_w("cfg_d3", 2, t0);
    chk("cfg_d3_nupd_s", upd_cyc_s.size(), 1);

    // Clear against a concurrent increment on channel 0
    clr[0] = 1'b1;
    step(1);
    clr[0] = 1'b0;
    chk("clr_w", vw(0), 0);
    chk("clr_s", vs(0), 0);
    b[0] = 1'b0;
    step(8);
    clear_log();
    clr[0] = 1'b1;
    a[0]   = 1'b1;
    step(8);
    clr[0] = 1'b0;
    step(8);
    chk("coll_val_w", vw(0), 0);
    chk("coll_val_s", vs(0), 0);
    chk("coll_nupd_w", upd_cyc_w.size(), 0);
    chk("coll_nupd_s", upd_cyc_s.size(), 0);
    chk("coll_other_ch", vw(2), 44);
    clear_log();
    b[0] = 1'b1;
    step(8);
    chk("coll_half_w", vw(0), 0);
    chk("coll_half_nupd", upd_cyc_w.size(), 0);
    clear_log();
    t0 = cyc;
    a[0] = 1'b0;
    step(8);
    chk("coll_next_w", vw(0), 1);
    chk("coll_next_s", vs(0), 1);
    chk_one_w("coll_next", 0, t0);

    // Zero step on channel 1 plus an out-of-range index write
    cfg_we = 1'b1; cfg_sel = 2'd1; cfg_step = 8'd0;
    step(1);
    cfg_sel = 2'd3; cfg_step = 8'd9;
    step(1);
    cfg_we = 1'b0;
    a[1] = 1'b0;
    step(8);
    clear_log();
    a[1] = 1'b1;
    step(8);
    chk("zero_step_w", vw(1), 1);
    chk("zero_step_s", vs(1), 1);
    chk("zero_step_nupd_w", upd_cyc_w.size(), 0);
    chk("zero_step_nupd_s", upd_cyc_s.size(), 0);

    // Simultaneous edges on all channels
    b[0] = 1'b0;
    a[1] = 1'b0;
    a[2] = 1'b0;
    cfg_we = 1'b1; cfg_sel = 2'd1; cfg_step = 8'd3;
    step(1);
    cfg_we = 1'b0;
    step(8);
    clear_log();
    a = '1;
    step(8);
    chk("sim_ch0_w", vw(0), 2);
    chk("sim_ch1_w", vw(1), 4);
    chk("sim_ch2_w", vw(2), 144);
    chk("sim_ch0_s", vs(0), 2);
    chk("sim_ch1_s", vs(1), 4);
    chk("sim_ch2_s", vs(2), 255);
    chk("sim_nupd_w", upd_cyc_w.size(), 3);
    chk("sim_nupd_s", upd_cyc_s.size(), 2);
    if (upd_cyc_w.size() == 3) begin
      for (int k = 1; k < 3; k++) begin
        chk("sim_consec", upd_cyc_w[k] - upd_cyc_w[k-1], 1);
        chk("sim_order", upd_ch_w[k], (upd_ch_w[k-1] + 1) % N);
      end
    end

    // Reset mid-scan with all pins high
    b = '1;
    step(8);
    clear_log();
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_values_w", values_w, 0);
    chk("mid_rst_values_s", values_s, 0);
    chk("mid_rst_upd", {upd_valid_w, upd_valid_s}, 0);
    chk("mid_rst_ptr", dut_w.ptr_q, 0);
    step(2);
    reset = 1'b1;
    clear_log();
    step(8);
    chk("post_rst_values_w", values_w, 0);
    chk("post_rst_values_s", values_s, 0);
    chk("post_rst_nupd", upd_cyc_w.size() + upd_cyc_s.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
